// File: rtl/dec_unbinder.sv
// Hypervector unbinder: rotates the bound vector back and searches a level memory for the
// level with the largest overlap. Define DEC_UNBINDER_EARLY_EXIT_EN to stop on an exact match.
module dec_unbinder #(
  parameter int unsigned HV_DIM     = 1024,
  parameter int unsigned NUM_LEVELS = 16,
  parameter int unsigned SHIFT      = 1,
  localparam int unsigned LVL_W     = $clog2(NUM_LEVELS),
  localparam int unsigned SCORE_W   = $clog2(HV_DIM + 1)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start_decoding,
  input  logic [HV_DIM-1:0]  bound_hv,
  output logic               lvl_rd_en,
  output logic [LVL_W-1:0]   lvl_addr,
  input  logic [HV_DIM-1:0]  lvl_data,
  output logic               busy,
  output logic               done,
  output logic [LVL_W-1:0]   level_idx,
  output logic [SCORE_W-1:0] match_score
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  localparam logic [LVL_W-1:0] LastAddr = LVL_W'(NUM_LEVELS - 1);

  function automatic logic [SCORE_W-1:0] popcnt(input logic [HV_DIM-1:0] v);
    logic [SCORE_W-1:0] c;
    c = '0;
    for (int i = 0; i < HV_DIM; i++) c = c + SCORE_W'(v[i]);
    return c;
  endfunction

  state_e              state_q, state_d;
  logic [LVL_W-1:0]    addr_q, addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [LVL_W-1:0]    rd_idx_q, rd_idx_d;
  logic [HV_DIM-1:0]   unbound_q, unbound_d;
  logic [SCORE_W-1:0]  best_score_q, best_score_d;
  logic [LVL_W-1:0]    best_idx_q, best_idx_d;
  logic [LVL_W-1:0]    level_idx_q, level_idx_d;
  logic [SCORE_W-1:0]  match_score_q, match_score_d;
  logic                done_q, done_d;
  logic [HV_DIM-1:0]   unbound_rot;
  logic [SCORE_W-1:0]  score;
  logic                cmp_en;
  logic                hit;

  // Right rotation undoes the encoder's left rotation; pure wiring.
  always_comb begin
    unbound_rot = '0;
    for (int unsigned j = 0; j < HV_DIM; j++) begin
      unbound_rot[j] = bound_hv[(j + SHIFT) % HV_DIM];
    end
  end

  assign score  = popcnt(unbound_q & lvl_data);
  // Late data (e.g. the read discarded after an early exit) never reaches the comparator.
  assign cmp_en = rd_valid_q && ((state_q == StFetch) || (state_q == StDrain));

`ifdef DEC_UNBINDER_EARLY_EXIT_EN
  logic [SCORE_W-1:0] full_q, full_d;
  assign hit = cmp_en && (score == full_q);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    unbound_d     = unbound_q;
    best_score_d  = best_score_q;
    best_idx_d    = best_idx_q;
    level_idx_d   = level_idx_q;
    match_score_d = match_score_q;
    done_d        = 1'b0;
    lvl_rd_en     = 1'b0;
`ifdef DEC_UNBINDER_EARLY_EXIT_EN
    full_d        = full_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_decoding) begin
          unbound_d    = unbound_rot;
          best_score_d = '0;
          best_idx_d   = '0;
          addr_d       = '0;
          state_d      = StFetch;
`ifdef DEC_UNBINDER_EARLY_EXIT_EN
          full_d       = popcnt(bound_hv);
`endif
        end
      end
      StFetch: begin
        lvl_rd_en = 1'b1;
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        done_d        = 1'b1;
        level_idx_d   = best_idx_q;
        match_score_d = best_score_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Strict compare keeps the lowest index on ties.
    if (cmp_en && (score > best_score_q)) begin
      best_score_d = score;
      best_idx_d   = rd_idx_q;
    end
    if (hit) begin
      state_d = StDone;
      addr_d  = '0;
    end
  end

  assign rd_valid_d = lvl_rd_en;
  assign rd_idx_d   = addr_q;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      rd_valid_q    <= 1'b0;
      rd_idx_q      <= '0;
      unbound_q     <= '0;
      best_score_q  <= '0;
      best_idx_q    <= '0;
      level_idx_q   <= '0;
      match_score_q <= '0;
      done_q        <= 1'b0;
`ifdef DEC_UNBINDER_EARLY_EXIT_EN
      full_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rd_valid_q    <= rd_valid_d;
      rd_idx_q      <= rd_idx_d;
      unbound_q     <= unbound_d;
      best_score_q  <= best_score_d;
      best_idx_q    <= best_idx_d;
      level_idx_q   <= level_idx_d;
      match_score_q <= match_score_d;
      done_q        <= done_d;
`ifdef DEC_UNBINDER_EARLY_EXIT_EN
      full_q        <= full_d;
`endif
    end
  end

  assign lvl_addr    = addr_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign level_idx   = level_idx_q;
  assign match_score = match_score_q;

endmodule

// File: tb/tb_dec_unbinder.sv
// Directed bench for dec_unbinder with a 1-cycle-latency level memory model.
module tb_dec_unbinder;

  localparam int unsigned HvDim  = 64;
  localparam int unsigned NLvl   = 16;
  localparam int unsigned Shift  = 3;
`ifdef DEC_UNBINDER_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic              start_decoding = 1'b0;
  logic [HvDim-1:0]  bound_hv = '0;
  logic              lvl_rd_en;
  logic [3:0]        lvl_addr;
  logic [HvDim-1:0]  lvl_data = '0;
  logic              busy;
  logic              done;
  logic [3:0]        level_idx;
  logic [6:0]        match_score;

  logic [HvDim-1:0]  lvl_mem [NLvl];
  int                n_checks = 0;
  int                n_fail = 0;
  int                done_cnt = 0;
  int                rd_cnt = 0;
  int                addr_err = 0;
  int                exp_addr = 0;

  dec_unbinder #(.HV_DIM(HvDim), .NUM_LEVELS(NLvl), .SHIFT(Shift)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start_decoding (start_decoding),
    .bound_hv       (bound_hv),
    .lvl_rd_en      (lvl_rd_en),
    .lvl_addr       (lvl_addr),
    .lvl_data       (lvl_data),
    .busy           (busy),
    .done           (done),
    .level_idx      (level_idx),
    .match_score    (match_score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (lvl_rd_en) lvl_data <= lvl_mem[lvl_addr];

  // Counts done pulses and reads, and flags any non-consecutive address sequence.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (lvl_rd_en) begin
      if (int'(lvl_addr) != exp_addr) addr_err++;
      exp_addr++;
      rd_cnt++;
    end else begin
      exp_addr = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HvDim-1:0] rotl(input logic [HvDim-1:0] v);
    return (v << Shift) | (v >> (HvDim - Shift));
  endfunction

  task automatic start_pulse(input logic [HvDim-1:0] bv);
    @(negedge clk);
    start_decoding = 1'b1;
    bound_hv       = bv;
    @(posedge clk);
    #1;
    start_decoding = 1'b0;
    bound_hv       = '1;
  endtask

  // Waits for done; x1/x2 give cycle offsets at which a stray start is presented.
  task automatic wait_done(input int x1, input int x2, output int lat);
    lat = 0;
    while (!done && lat < 60) begin
      start_decoding = ((lat + 1) == x1) || ((lat + 1) == x2);
      @(posedge clk);
      #1;
      lat++;
    end
    start_decoding = 1'b0;
  endtask

  task automatic run(input string tag, input logic [HvDim-1:0] bv, input int x1, input int x2,
                     input int exp_idx, input int exp_score, input int hit_idx);
    int lat;
    int rd_base;
    int done_base;
    rd_base   = rd_cnt;
    done_base = done_cnt;
    start_pulse(bv);
    wait_done(x1, x2, lat);
    check_eq({tag, "_latency"}, lat, Early ? hit_idx + 3 : NLvl + 2);
    check_eq({tag, "_idx"}, level_idx, exp_idx);
    check_eq({tag, "_score"}, match_score, exp_score);
    check_eq({tag, "_reads"}, rd_cnt - rd_base, Early ? hit_idx + 2 : NLvl);
    repeat (25) @(posedge clk);
    #1;
    check_eq({tag, "_one_done"}, done_cnt - done_base, 1);
    check_eq({tag, "_hold_idx"}, level_idx, exp_idx);
  endtask

  localparam logic [HvDim-1:0] LvlA = 64'h0F0F_0000_0000_00FF;  // 16 ones
  localparam logic [HvDim-1:0] VecU = 64'h0000_00FF_FFFF_FFFF;  // 40 ones

  task automatic load_mem_a();
    for (int k = 0; k < NLvl; k++) begin
      lvl_mem[k] = ~LvlA & (64'hDEAD_BEEF_CAFE_F00D ^ (64'h0101_0101_0101_0101 * k));
    end
    lvl_mem[5] = LvlA;
  endtask

  task automatic load_mem_b();
    for (int k = 0; k < NLvl; k++) lvl_mem[k] = VecU & ~(64'h1 << k);
    lvl_mem[2] = VecU;
    lvl_mem[9] = VecU | 64'hFF00_0000_0000_0000;
  endtask

  initial begin
    int done_base;
    load_mem_a();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_en", lvl_rd_en, 0);
    check_eq("rst_addr", lvl_addr, 0);
    check_eq("rst_idx", level_idx, 0);
    check_eq("rst_score", match_score, 0);
    @(negedge clk);
    nrst = 1'b0;

    run("exact_l5", rotl(LvlA), -1, -1, 5, 16, 5);
    check_eq("addr_seq", addr_err, 0);
    load_mem_b();
    run("tie_2_9", rotl(VecU), -1, -1, 2, 40, 2);
    run("zeros", '0, -1, -1, 0, 0, 0);
    load_mem_a();
    run("busy_start", rotl(LvlA), 1, Early ? 5 : 10, 5, 16, 5);

    // Reset in the middle of a search.
    done_base = done_cnt;
    start_pulse(rotl(LvlA));
    repeat (6) @(posedge clk);
    #1;
    check_eq("mid_busy_pre", busy, 1);
    nrst = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_rd_en", lvl_rd_en, 0);
    check_eq("mid_rst_addr", lvl_addr, 0);
    check_eq("mid_rst_idx", level_idx, 0);
    check_eq("mid_rst_score", match_score, 0);
    @(negedge clk);
    nrst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("mid_rst_no_done", done_cnt - done_base, 0);
    load_mem_b();
    run("after_rst", rotl(VecU), -1, -1, 2, 40, 2);
    check_eq("addr_seq_final", addr_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
